// File: rtl/axi_arb_pkg.sv
// Shared constants, index-width helper and FSM state type for the AXI read arbiter.
package axi_arb_pkg;

    // AXI encodings used on the AR channel and for checking RRESP.
    localparam logic [2:0] AXI_SIZE_8B       = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

    // Width of a requester index; a single-bit index is kept even for tiny N.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // AR issue FSM: IDLE has no request in the AR regs, ISSUE presents one.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axi_mem_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    int cand;

    // Scan from furthest to nearest so the last hit written is the closest to the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_mem_read_arbiter.sv
// Shares one AXI4 read port among N_PORTS requesters: round-robin AR issue with
// per-requester in-flight limits, ARID tagging, and RID-based R beat routing.
module axi_mem_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int         N_PORTS   = 4,
    parameter int         MAX_OUTST = 8,
    parameter logic [5:0] ID_BASE   = 6'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_PORTS-1:0]     rq_arvalid,
    output logic [N_PORTS-1:0]     rq_arready,
    input  logic [N_PORTS*32-1:0]  rq_araddr,
    input  logic [N_PORTS*8-1:0]   rq_arlen,
    output logic [N_PORTS-1:0]     rq_rvalid,
    input  logic [N_PORTS-1:0]     rq_rready,
    output logic [63:0]            rq_rdata,
    output logic                   rq_rlast,
    output logic                   mem_ARVALID,
    input  logic                   mem_ARREADY,
    output logic [31:0]            mem_ARADDR,
    output logic [7:0]             mem_ARLEN,
    output logic [5:0]             mem_ARID,
    output logic [2:0]             mem_ARSIZE,
    output logic [1:0]             mem_ARBURST,
    output logic                   mem_ARLOCK,
    output logic [3:0]             mem_ARCACHE,
    output logic [2:0]             mem_ARPROT,
    output logic [3:0]             mem_ARQOS,
    output logic                   mem_RREADY,
    input  logic                   mem_RVALID,
    input  logic [63:0]            mem_RDATA,
    input  logic [5:0]             mem_RID,
    input  logic                   mem_RLAST,
    input  logic [1:0]             mem_RRESP,
    output logic                   err_rid,
    output logic                   err_rresp
);

    localparam int             IDX_W   = idx_width(N_PORTS);
    localparam int             CNT_W   = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    arb_state_e       state_q, state_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [5:0]       arid_q, arid_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] outst_q [N_PORTS];
    logic [CNT_W-1:0] outst_d [N_PORTS];
    logic             err_rid_q, err_rid_d;
    logic             err_rresp_q, err_rresp_d;

    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] beat_done;
    logic [N_PORTS-1:0] rd_sel;
    logic [N_PORTS-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               arb_en;
    logic               accept;
    logic [IDX_W-1:0]   rid_idx;
    logic               rid_hit;

    // ---------------- R channel demux ----------------
    assign rid_idx = mem_RID[IDX_W-1:0];
    assign rid_hit = (mem_RID[5:IDX_W] == ID_BASE[5:IDX_W]) && (int'(rid_idx) < N_PORTS);

    // Per-requester routing, last-beat detection and AR eligibility. A last beat
    // retiring this cycle frees its slot for a request arbitrated in the same cycle.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        assign rd_sel[gi]    = (rid_idx == IDX_W'(gi));
        assign rq_rvalid[gi] = mem_RVALID && rid_hit && rd_sel[gi];
        assign beat_done[gi] = rq_rvalid[gi] && rq_rready[gi] && mem_RLAST;
        assign eligible[gi]  = rq_arvalid[gi] && ((outst_q[gi] < MAX_CNT) || beat_done[gi]);

        // In-flight burst count: +1 on accept, -1 on retired last beat, both cancel.
        always_comb begin
            outst_d[gi] = outst_q[gi];
            if (rq_arready[gi] && !beat_done[gi]) begin
                outst_d[gi] = outst_q[gi] + 1'b1;
            end else if (!rq_arready[gi] && beat_done[gi] && (outst_q[gi] != '0)) begin
                outst_d[gi] = outst_q[gi] - 1'b1;
            end
        end

        // Outstanding counter register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                outst_q[gi] <= '0;
            end else begin
                outst_q[gi] <= outst_d[gi];
            end
        end
    end

    // Unmapped IDs are always accepted so a stray beat cannot stall the bus.
    assign mem_RREADY = rid_hit ? |(rq_rready & rd_sel) : 1'b1;
    assign rq_rdata   = mem_RDATA;
    assign rq_rlast   = mem_RLAST;

    // ---------------- AR arbitration ----------------
    rr_arbiter #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The AR regs may be reloaded only when empty or when the current AR handshakes.
    assign arb_en     = (state_q == IDLE) || mem_ARREADY;
    assign accept     = arb_en && grant_any;
    assign rq_arready = accept ? grant : '0;

    // Next-state, AR register load and pointer advance.
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arid_d   = arid_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (mem_ARREADY && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            araddr_d = rq_araddr[int'(grant_idx)*32 +: 32];
            arlen_d  = rq_arlen[int'(grant_idx)*8 +: 8];
            arid_d   = ID_BASE | 6'(grant_idx);
            rr_ptr_d = (int'(grant_idx) == N_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_comb begin
        err_rid_d   = err_rid_q | (mem_RVALID && !rid_hit);
        err_rresp_d = err_rresp_q | (mem_RVALID && mem_RREADY && (mem_RRESP != AXI_RESP_OKAY));
    end

    // State, AR register, pointer and error flag storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arid_q      <= '0;
            rr_ptr_q    <= '0;
            err_rid_q   <= 1'b0;
            err_rresp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arid_q      <= arid_d;
            rr_ptr_q    <= rr_ptr_d;
            err_rid_q   <= err_rid_d;
            err_rresp_q <= err_rresp_d;
        end
    end

    assign mem_ARVALID = (state_q == ISSUE);
    assign mem_ARADDR  = araddr_q;
    assign mem_ARLEN   = arlen_q;
    assign mem_ARID    = arid_q;
    assign mem_ARSIZE  = AXI_SIZE_8B;
    assign mem_ARBURST = AXI_BURST_INCR;
    assign mem_ARLOCK  = 1'b0;
    assign mem_ARCACHE = AXI_CACHE_BUF_MOD;
    assign mem_ARPROT  = 3'b000;
    assign mem_ARQOS   = 4'b0000;
    assign err_rid     = err_rid_q;
    assign err_rresp   = err_rresp_q;

endmodule

// File: tb/tb_axi_mem_read_arbiter.sv
// Bench for axi_mem_read_arbiter (4 ports, 2 in-flight bursts per port).
module tb_axi_mem_read_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    rq_arvalid, rq_arready, rq_rvalid, rq_rready;
    logic [N*32-1:0] rq_araddr;
    logic [N*8-1:0]  rq_arlen;
    logic [63:0]     rq_rdata, mem_RDATA;
    logic            rq_rlast, mem_ARVALID, mem_ARREADY, mem_ARLOCK, mem_RREADY;
    logic            mem_RVALID, mem_RLAST, err_rid, err_rresp;
    logic [31:0]     mem_ARADDR;
    logic [7:0]      mem_ARLEN;
    logic [5:0]      mem_ARID, mem_RID;
    logic [2:0]      mem_ARSIZE, mem_ARPROT;
    logic [1:0]      mem_ARBURST, mem_RRESP;
    logic [3:0]      mem_ARCACHE, mem_ARQOS;

    always #5 clk = ~clk;

    axi_mem_read_arbiter #(.N_PORTS(N), .MAX_OUTST(2), .ID_BASE(6'h00)) dut (
        .clk(clk), .reset(reset),
        .rq_arvalid(rq_arvalid), .rq_arready(rq_arready),
        .rq_araddr(rq_araddr), .rq_arlen(rq_arlen),
        .rq_rvalid(rq_rvalid), .rq_rready(rq_rready),
        .rq_rdata(rq_rdata), .rq_rlast(rq_rlast),
        .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY),
        .mem_ARADDR(mem_ARADDR), .mem_ARLEN(mem_ARLEN), .mem_ARID(mem_ARID),
        .mem_ARSIZE(mem_ARSIZE), .mem_ARBURST(mem_ARBURST), .mem_ARLOCK(mem_ARLOCK),
        .mem_ARCACHE(mem_ARCACHE), .mem_ARPROT(mem_ARPROT), .mem_ARQOS(mem_ARQOS),
        .mem_RREADY(mem_RREADY), .mem_RVALID(mem_RVALID), .mem_RDATA(mem_RDATA),
        .mem_RID(mem_RID), .mem_RLAST(mem_RLAST), .mem_RRESP(mem_RRESP),
        .err_rid(err_rid), .err_rresp(err_rresp)
    );

    typedef struct { logic [5:0] id; logic [31:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { logic [3:0] port; logic [63:0] data; logic last; } r_exp_t;
    typedef struct {
        logic [3:0] av; logic ar; logic rv; logic [5:0] rid; logic rl; logic [1:0] rs; logic [3:0] rr;
        logic [3:0] ea; logic ev; logic [5:0] eid; logic [3:0] erv; logic emr; logic eerid; logic eerr;
    } vec_t;

    ar_exp_t     exp_ar[$];
    r_exp_t      exp_r[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_hs  = 0;
    logic [31:0] port_addr [N];
    logic [7:0]  port_len  [N];
    vec_t        tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] av, input logic ar, input logic rv, input logic [5:0] rid,
                                input logic rl, input logic [1:0] rs, input logic [3:0] rr,
                                input logic [3:0] ea, input logic ev, input logic [5:0] eid,
                                input logic [3:0] erv, input logic emr, input logic eerid, input logic eerr);
        vec_t v;
        v.av = av; v.ar = ar; v.rv = rv; v.rid = rid; v.rl = rl; v.rs = rs; v.rr = rr;
        v.ea = ea; v.ev = ev; v.eid = eid; v.erv = erv; v.emr = emr; v.eerid = eerid; v.eerr = eerr;
        return v;
    endfunction

    task automatic load_ports();
        for (int i = 0; i < N; i++) begin
            rq_araddr[32*i +: 32] = port_addr[i];
            rq_arlen[8*i +: 8]    = port_len[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rq_arvalid = '0; rq_rready = '0; mem_ARREADY = 1'b0; mem_RVALID = 1'b0;
        mem_RID = '0; mem_RLAST = 1'b0; mem_RRESP = '0; mem_RDATA = '0;
        exp_ar.delete();
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_ar(input int p);
        ar_exp_t e;
        e.id = 6'(p); e.addr = port_addr[p]; e.len = port_len[p];
        exp_ar.push_back(e);
    endtask

    // AR scoreboard: each handshake pops the oldest expected request.
    always @(negedge clk) begin
        if (!reset && mem_ARVALID && mem_ARREADY) begin
            n_hs++;
            if (exp_ar.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL ar_unexpected: got id 0x%0h, want no AR", mem_ARID);
            end else begin
                ar_exp_t e;
                e = exp_ar.pop_front();
                $display("AR  id=%02h addr=%08h len=%0d", mem_ARID, mem_ARADDR, mem_ARLEN);
                chk("ar_id", 64'(mem_ARID), 64'(e.id));
                chk("ar_addr", 64'(mem_ARADDR), 64'(e.addr));
                chk("ar_len", 64'(mem_ARLEN), 64'(e.len));
            end
        end
    end

    // R scoreboard: each delivered beat pops the oldest expected beat.
    always @(negedge clk) begin
        if (!reset && ((rq_rvalid & rq_rready) != '0)) begin
            if (exp_r.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL r_unexpected: got rvalid 0x%0h, want no beat", rq_rvalid);
            end else begin
                r_exp_t e;
                e = exp_r.pop_front();
                $display("R   port=%b data=%016h last=%0b", rq_rvalid, rq_rdata, rq_rlast);
                chk("r_port", 64'(rq_rvalid), 64'(e.port));
                chk("r_data", rq_rdata, e.data);
                chk("r_last", 64'(rq_rlast), 64'(e.last));
            end
        end
    end

    initial begin
        int hs0;
        rq_araddr = '0; rq_arlen = '0;
        for (int i = 0; i < N; i++) begin
            port_addr[i] = 32'h0002_0000 + 32'(i * 64);
            port_len[i]  = 8'(2 * i + 1);
        end
        load_ports();

        // Table: av ar rv rid rl rs rr | ea ev eid erv emr eerid eerr
        tbl[0]  = mk(4'b1111,1,0,6'h00,0,2'd0,4'b0000, 4'b0001,0,6'h00,4'b0000,0,0,0);
        tbl[1]  = mk(4'b1111,1,0,6'h00,0,2'd0,4'b0000, 4'b0010,1,6'h00,4'b0000,0,0,0);
        tbl[2]  = mk(4'b1111,1,0,6'h00,0,2'd0,4'b0000, 4'b0100,1,6'h01,4'b0000,0,0,0);
        tbl[3]  = mk(4'b1111,1,0,6'h00,0,2'd0,4'b0000, 4'b1000,1,6'h02,4'b0000,0,0,0);
        tbl[4]  = mk(4'b1111,1,0,6'h00,0,2'd0,4'b0000, 4'b0001,1,6'h03,4'b0000,0,0,0);
        tbl[5]  = mk(4'b0000,1,0,6'h00,0,2'd0,4'b0000, 4'b0000,1,6'h00,4'b0000,0,0,0);
        tbl[6]  = mk(4'b0000,1,0,6'h00,0,2'd0,4'b0000, 4'b0000,0,6'h00,4'b0000,0,0,0);
        tbl[7]  = mk(4'b0001,1,0,6'h00,0,2'd0,4'b0000, 4'b0000,0,6'h00,4'b0000,0,0,0);
        tbl[8]  = mk(4'b0001,1,0,6'h00,0,2'd0,4'b0000, 4'b0000,0,6'h00,4'b0000,0,0,0);
        tbl[9]  = mk(4'b0001,1,1,6'h00,1,2'd0,4'b0001, 4'b0001,0,6'h00,4'b0001,1,0,0);
        tbl[10] = mk(4'b0000,1,0,6'h00,0,2'd0,4'b0000, 4'b0000,1,6'h00,4'b0000,0,0,0);
        tbl[11] = mk(4'b0001,1,0,6'h00,0,2'd0,4'b0000, 4'b0000,0,6'h00,4'b0000,0,0,0);
        tbl[12] = mk(4'b0000,1,1,6'h01,0,2'd0,4'b0010, 4'b0000,0,6'h00,4'b0010,1,0,0);
        tbl[13] = mk(4'b0000,1,1,6'h01,1,2'd0,4'b0010, 4'b0000,0,6'h00,4'b0010,1,0,0);
        tbl[14] = mk(4'b0000,1,1,6'h02,1,2'd0,4'b0000, 4'b0000,0,6'h00,4'b0100,0,0,0);
        tbl[15] = mk(4'b0000,1,1,6'h02,1,2'd0,4'b0100, 4'b0000,0,6'h00,4'b0100,1,0,0);
        tbl[16] = mk(4'b0000,1,1,6'h3F,1,2'd0,4'b0000, 4'b0000,0,6'h00,4'b0000,1,0,0);
        tbl[17] = mk(4'b0000,1,1,6'h03,1,2'd2,4'b1000, 4'b0000,0,6'h00,4'b1000,1,1,0);
        tbl[18] = mk(4'b0000,1,0,6'h00,0,2'd0,4'b0000, 4'b0000,0,6'h00,4'b0000,0,1,1);

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_arvalid", 64'(mem_ARVALID), 64'd0);
        chk("rst_arready", 64'(rq_arready), 64'd0);
        chk("rst_rvalid", 64'(rq_rvalid), 64'd0);
        chk("rst_rready", 64'(mem_RREADY), 64'd0);
        chk("rst_arid", 64'(mem_ARID), 64'd0);
        chk("rst_araddr", 64'(mem_ARADDR), 64'd0);
        chk("rst_err", 64'({err_rid, err_rresp}), 64'd0);
        step();

        // Single request from port 1, then a 4-beat burst back to it.
        port_addr[1] = 32'h0000_1000; port_len[1] = 8'd3; load_ports();
        rq_arvalid = 4'b0010;
        push_ar(1);
        @(negedge clk);
        chk("t1_arready", 64'(rq_arready), 64'b0010);
        chk("t1_arvalid_same_cycle", 64'(mem_ARVALID), 64'd0);
        step();
        rq_arvalid = '0; mem_ARREADY = 1'b1;
        @(negedge clk);
        chk("t1_arvalid", 64'(mem_ARVALID), 64'd1);
        chk("t1_arid", 64'(mem_ARID), 64'h01);
        chk("t1_arlen", 64'(mem_ARLEN), 64'd3);
        chk("t1_arsize", 64'(mem_ARSIZE), 64'b011);
        chk("t1_arburst", 64'(mem_ARBURST), 64'b01);
        chk("t1_arcache", 64'(mem_ARCACHE), 64'b0011);
        chk("t1_ar_misc", 64'({mem_ARLOCK, mem_ARPROT, mem_ARQOS}), 64'd0);
        step();
        mem_ARREADY = 1'b0;
        @(negedge clk);
        chk("t1_arvalid_done", 64'(mem_ARVALID), 64'd0);
        step();
        rq_rready = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            r_exp_t e;
            mem_RVALID = 1'b1; mem_RID = 6'h01; mem_RLAST = (b == 3);
            mem_RDATA = 64'h1111_0000_0000_0000 + 64'(b);
            e.port = 4'b0010; e.data = mem_RDATA; e.last = mem_RLAST;
            exp_r.push_back(e);
            @(negedge clk);
            chk("t1_rvalid", 64'(rq_rvalid), 64'b0010);
            chk("t1_mem_rready", 64'(mem_RREADY), 64'd1);
            step();
        end
        mem_RVALID = 1'b0;

        // Table: round-robin, in-flight cap with same-cycle release, routing, errors.
        do_reset();
        port_addr[1] = 32'h0002_0040; port_len[1] = 8'd3; load_ports();
        for (int r = 0; r < 19; r++) begin
            vec_t v;
            v = tbl[r];
            rq_arvalid = v.av; mem_ARREADY = v.ar; mem_RVALID = v.rv; mem_RID = v.rid;
            mem_RLAST = v.rl; mem_RRESP = v.rs; rq_rready = v.rr;
            mem_RDATA = 64'hA5A5_0000_0000_0000 | 64'(r);
            for (int i = 0; i < N; i++) if (v.ea[i]) push_ar(i);
            if ((v.erv & v.rr) != '0) begin
                r_exp_t e;
                e.port = v.erv; e.data = mem_RDATA; e.last = v.rl;
                exp_r.push_back(e);
            end
            @(negedge clk);
            chk($sformatf("v%0d_arready", r), 64'(rq_arready), 64'(v.ea));
            chk($sformatf("v%0d_arvalid", r), 64'(mem_ARVALID), 64'(v.ev));
            if (v.ev) chk($sformatf("v%0d_arid", r), 64'(mem_ARID), 64'(v.eid));
            chk($sformatf("v%0d_rvalid", r), 64'(rq_rvalid), 64'(v.erv));
            chk($sformatf("v%0d_mem_rready", r), 64'(mem_RREADY), 64'(v.emr));
            chk($sformatf("v%0d_err_rid", r), 64'(err_rid), 64'(v.eerid));
            chk($sformatf("v%0d_err_rresp", r), 64'(err_rresp), 64'(v.eerr));
            step();
        end

        // ARREADY held low: AR stable, no new grants, one handshake on release.
        do_reset();
        rq_arvalid = 4'b0100;
        push_ar(2);
        @(negedge clk);
        chk("t4_grant", 64'(rq_arready), 64'b0100);
        step();
        rq_arvalid = 4'b0001;
        hs0 = n_hs;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_arvalid", 64'(mem_ARVALID), 64'd1);
            chk("t4_arid", 64'(mem_ARID), 64'h02);
            chk("t4_araddr", 64'(mem_ARADDR), 64'(port_addr[2]));
            chk("t4_arlen", 64'(mem_ARLEN), 64'(port_len[2]));
            chk("t4_no_arready", 64'(rq_arready), 64'd0);
            step();
        end
        rq_arvalid = '0; mem_ARREADY = 1'b1;
        @(negedge clk);
        chk("t4_release_arvalid", 64'(mem_ARVALID), 64'd1);
        step();
        @(negedge clk);
        chk("t4_after_arvalid", 64'(mem_ARVALID), 64'd0);
        chk("t4_handshakes", 64'(n_hs - hs0), 64'd1);
        step();

        // Reset while ISSUE with port 0 at its cap; traffic afterwards starts at port 0.
        do_reset();
        rq_arvalid = 4'b0001; mem_ARREADY = 1'b1;
        push_ar(0);
        @(negedge clk);
        chk("t6_grant0", 64'(rq_arready), 64'b0001);
        step();
        push_ar(0);
        @(negedge clk);
        chk("t6_grant1", 64'(rq_arready), 64'b0001);
        step();
        mem_ARREADY = 1'b0;
        @(negedge clk);
        chk("t6_capped", 64'(rq_arready), 64'd0);
        chk("t6_issue", 64'(mem_ARVALID), 64'd1);
        #2;
        rq_arvalid = '0; reset = 1'b1;
        #1;
        chk("t6_async_arvalid", 64'(mem_ARVALID), 64'd0);
        chk("t6_rst_arready", 64'(rq_arready), 64'd0);
        exp_ar.delete();
        step();
        reset = 1'b0;
        rq_arvalid = 4'b1111; mem_ARREADY = 1'b1;
        push_ar(0);
        @(negedge clk);
        chk("t6_post_grant0", 64'(rq_arready), 64'b0001);
        step();
        push_ar(1);
        @(negedge clk);
        chk("t6_post_grant1", 64'(rq_arready), 64'b0010);
        step();
        rq_arvalid = '0;
        step();
        @(negedge clk);
        chk("t6_idle", 64'(mem_ARVALID), 64'd0);
        step();

        chk("ar_drained", 64'(exp_ar.size()), 64'd0);
        chk("r_drained", 64'(exp_r.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
